man_decoding_slave: RTL
=======================

// Module: man_decoding_slave
// PURPOSE
//   AS-i slave-response Manchester decoder. Pairs with the master request encoder.
//   After the encoder finishes a request, this block waits for the slave's 7-bit reply:
//     ST=0, I3..I0, PB, EB=1, sent MSB first.
//   Line coding matches the encoder:
//     bit 1 = "01" (low half, then high half); bit 0 = "10"; idle line = 1.
//   It checks the frame and delivers the 4 info bits, or flags an error or a timeout.
// PARAMETERS
//   HALF_BIT_CLKS  150   clk_in cycles per Manchester half-bit (3 us at 50 MHz)
//   TIMEOUT_CLKS   3000  cycles after arm with no start edge -> timeout (10 bit times)
// PORTS
//   clk_in       in   1  single clock; all logic on its rising edge
//   rst          in   1  synchronous, active-high reset
//   line_in      in   1  raw AS-i receive line (asynchronous; idle high)
//   arm          in   1  1-cycle pulse; master request sent, open the response window
//   busy         out  1  high from accepted arm until the frame completes or times out
//   rsp_data     out  4  {I3,I2,I1,I0}; updated only together with rsp_valid
//   rsp_valid    out  1  1-cycle pulse; good frame received
//   rsp_err      out  1  1-cycle pulse; frame received with at least one error
//   err_flags    out  3  {manchester, parity, end_bit}; valid with rsp_err, else 0
//   rsp_timeout  out  1  1-cycle pulse; no start edge within TIMEOUT_CLKS
// BEHAVIOUR
//   Reset values: all outputs 0; FSM in IDLE; counters 0.
//   Reset mid-frame aborts with no pulse.
//   line_in passes through a 2-FF synchronizer. All timing below refers to the synced
//   line s. A falling edge (fe) is s==0 while the previous s==1.
//   States: IDLE -> WAIT_START -> START_CHK -> RX_BITS -> REPORT -> IDLE.
//   IDLE:
//     - arm=1 -> WAIT_START; clear the timeout counter; busy=1 next cycle.
//     - Edges on s are ignored while in IDLE.
//   WAIT_START:
//     - arm is ignored while busy.
//     - fe at cycle T marks mid-start-bit -> START_CHK.
//     - Timeout counter reaching TIMEOUT_CLKS-1 with no fe -> pulse rsp_timeout, go to
//       IDLE, busy=0.
//     - fe in the terminal-count cycle wins over the timeout.
//   START_CHK:
//     - Sample s at T+HALF_BIT_CLKS/2.
//     - s==1 is a glitch: return to WAIT_START. The timeout counter keeps running
//       from its current value and is not reset.
//     - s==0 -> RX_BITS.
//   RX_BITS, for bit k = 1..6 (I3, I2, I1, I0, PB, EB):
//     - a_k = s at T + 2k*H - H/2; b_k = s at T + 2k*H + H/2, where H = HALF_BIT_CLKS.
//     - Bit value = b_k.
//     - a_k == b_k sets the manchester flag; decoding continues so the full frame is
//       consumed.
//     - The sample counter is one free-running down-counter reloaded every half-bit.
//       There is no edge resync; the budget is <= H/4 drift over the frame.
//   REPORT, the cycle after b_6 is taken:
//     - parity flag = PB != ^{I3..I0} (even parity over the info bits).
//     - end_bit flag = EB != 1.
//     - All flags 0 -> rsp_valid=1 and rsp_data <= I.
//     - Otherwise rsp_err=1 and err_flags <= flags; rsp_data holds its old value.
//     - err_flags returns to 0 the next cycle. busy=0 the next cycle, then IDLE.
//   Total latency from fe to the output pulse: 12*H + H/2 + 1 cycles.
//   rsp_valid, rsp_err and rsp_timeout are mutually exclusive, at most one per arm.
//   Counter width: $clog2(max(TIMEOUT_CLKS, 2*HALF_BIT_CLKS) + 1). No wrap is possible.
//   HALF_BIT_CLKS must be >= 4 and even.
// STRUCTURE
//   asi_pkg:
//     - RSP_BITS=7, REQ_BITS=14
//     - err_flags bit indices ERR_MAN=2, ERR_PAR=1, ERR_EB=0
//     - FSM state localparams / enum
//   Sub-module man_sync_edge: 2-FF synchronizer plus falling-edge detect.
//     Outputs s and fe. Reused by the future slave-side decoder.
// TESTING (bench HALF_BIT_CLKS=4, TIMEOUT_CLKS=100)
//   1. arm, then drive a good frame I=4'b1010, PB=0, EB=1
//      -> one rsp_valid, rsp_data=4'hA, err_flags=0, fe-to-pulse = 51 cycles.
//   2. Frame I=4'b0001, PB=0 -> rsp_err once, err_flags=3'b010, rsp_data unchanged.
//   3. Hold the line low for all of bit I1, rest valid -> rsp_err, err_flags[2]=1.
//   4. EB sent as 0 ("10") -> rsp_err, err_flags=3'b001.
//   5. arm with the line idle -> rsp_timeout exactly 100 cycles after arm, busy falls.
//      Then a 1-cycle low glitch after a new arm -> no frame, busy stays 1.
//   6. rst asserted in the middle of bit 3 -> all outputs 0 the next cycle, no pulse.
//      A later arm plus a good frame decodes correctly.

Source files
------------

// File: rtl/asi_pkg.sv
// ---------------------------------------------------------------------------
// asi_pkg
//   Shared constants and types for the AS-i Manchester request/response path.
//   - RSP_BITS / REQ_BITS : frame lengths of slave reply and master request
//   - ERR_MAN/ERR_PAR/ERR_EB : bit positions inside err_flags
//   - rx_state_t : response decoder FSM states
//   - max2 : helper used when sizing counters
// ---------------------------------------------------------------------------
package asi_pkg;

    localparam int RSP_BITS = 7;
    localparam int REQ_BITS = 14;

    localparam int ERR_MAN = 2;
    localparam int ERR_PAR = 1;
    localparam int ERR_EB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_START_CHK  = 3'd2,
        ST_RX_BITS    = 3'd3,
        ST_REPORT     = 3'd4
    } rx_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/man_sync_edge.sv
// ---------------------------------------------------------------------------
// man_sync_edge
//   Two-flop synchronizer for an asynchronous, idle-high line plus a
//   falling-edge detector on the synchronized value.
// Ports
//   clk_in  in  1  clock
//   rst     in  1  synchronous active-high reset (flops return to idle-high)
//   line_in in  1  asynchronous line
//   s       out 1  synchronized line
//   fe      out 1  high for one cycle when s is 0 and was 1 the cycle before
// ---------------------------------------------------------------------------
module man_sync_edge (
    input  logic clk_in,
    input  logic rst,
    input  logic line_in,
    output logic s,
    output logic fe
);

    logic s_meta;
    logic s_q;
    logic s_prev;

    // Reset to 1 (idle level) so leaving reset never fakes a falling edge.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            s_meta <= 1'b1;
            s_q    <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            s_meta <= line_in;
            s_q    <= s_meta;
            s_prev <= s_q;
        end
    end

    assign s  = s_q;
    assign fe = s_prev & ~s_q;

endmodule

// File: rtl/man_decoding_slave.sv
// ---------------------------------------------------------------------------
// man_decoding_slave
//   AS-i slave-response Manchester decoder. After arm, waits for the 7-bit
//   reply ST=0, I3..I0, PB, EB=1 (MSB first; bit 1 = "01", bit 0 = "10",
//   idle high) and reports the info nibble, an error, or a timeout.
// Ports
//   clk_in      in  1  clock
//   rst         in  1  synchronous active-high reset
//   line_in     in  1  raw receive line (asynchronous, idle high)
//   arm         in  1  pulse: open the response window
//   busy        out 1  high while a response window is open
//   rsp_data    out 4  {I3,I2,I1,I0}, updated only with rsp_valid
//   rsp_valid   out 1  pulse: good frame
//   rsp_err     out 1  pulse: frame with errors
//   err_flags   out 3  {manchester, parity, end_bit}, non-zero only with rsp_err
//   rsp_timeout out 1  pulse: no start edge within TIMEOUT_CLKS
//   fsm_state   out 3  current FSM state (debug)
//
// Handshake: arm is a single-cycle request accepted only when busy is low;
// exactly one of rsp_valid / rsp_err / rsp_timeout pulses for each accepted
// arm unless rst intervenes, and busy drops the cycle after that pulse.
// ---------------------------------------------------------------------------
module man_decoding_slave
    import asi_pkg::*;
#(
    parameter int HALF_BIT_CLKS = 150,
    parameter int TIMEOUT_CLKS  = 3000
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       line_in,
    input  logic       arm,
    output logic       busy,
    output logic [3:0] rsp_data,
    output logic       rsp_valid,
    output logic       rsp_err,
    output logic [2:0] err_flags,
    output logic       rsp_timeout,
    output logic [2:0] fsm_state
);

    localparam int CNT_W = $clog2(max2(TIMEOUT_CLKS, 2 * HALF_BIT_CLKS) + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF_BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] MID_M1  = CNT_W'(HALF_BIT_CLKS / 2 - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [3:0]       LAST_HALF = 4'd11;

    logic s;
    logic fe;

    man_sync_edge u_sync (
        .clk_in  (clk_in),
        .rst     (rst),
        .line_in (line_in),
        .s       (s),
        .fe      (fe)
    );

    rx_state_t        state;
    rx_state_t        state_next;
    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W-1:0] smp_cnt;
    logic [3:0]       half_idx;   // 0..11: even = first-half sample, odd = second
    logic [4:0]       bits;       // b_1..b_5 as they arrive, b_1 ends up in [4]
    logic             a_smp;      // first-half sample of the current bit
    logic             man_err;

    logic             smp_tick;
    logic             timeout_hit;
    logic             last_smp;
    logic [5:0]       frame;
    logic [2:0]       flags;

    assign smp_tick = (smp_cnt == '0);
    assign last_smp = (state == ST_RX_BITS) && smp_tick && (half_idx == LAST_HALF);

    // Complete frame as seen on the cycle b_6 is sampled: {I3..I0, PB, EB}.
    assign frame = {bits, s};

    always_comb begin
        flags          = '0;
        flags[ERR_MAN] = man_err | (a_smp == s);
        flags[ERR_PAR] = frame[1] ^ (^frame[5:2]);
        flags[ERR_EB]  = ~frame[0];
    end

    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm) state_next = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                // A start edge in the terminal cycle takes priority.
                if (fe) begin
                    state_next = ST_START_CHK;
                end else if (to_cnt >= TO_LAST) begin
                    state_next  = ST_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            ST_START_CHK: begin
                if (smp_tick) state_next = s ? ST_WAIT_START : ST_RX_BITS;
            end
            ST_RX_BITS: begin
                if (last_smp) state_next = ST_REPORT;
            end
            ST_REPORT: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= ST_IDLE;
            to_cnt    <= '0;
            smp_cnt   <= '0;
            half_idx  <= '0;
            bits      <= '0;
            a_smp     <= 1'b0;
            man_err   <= 1'b0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            err_flags <= '0;
        end else begin
            state     <= state_next;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            err_flags <= '0;
            case (state)
                ST_IDLE: begin
                    if (arm) to_cnt <= '0;
                end
                ST_WAIT_START: begin
                    if (to_cnt < TO_LAST) to_cnt <= to_cnt + 1'b1;
                    // fe marks mid-start-bit; first check lands half a half-bit later.
                    if (fe) smp_cnt <= MID_M1;
                end
                ST_START_CHK: begin
                    // Timeout keeps counting so a glitch cannot extend the window.
                    if (to_cnt < TO_LAST) to_cnt <= to_cnt + 1'b1;
                    if (smp_tick) begin
                        smp_cnt  <= HALF_M1;
                        half_idx <= '0;
                        man_err  <= 1'b0;
                    end else begin
                        smp_cnt <= smp_cnt - 1'b1;
                    end
                end
                ST_RX_BITS: begin
                    if (smp_tick) begin
                        smp_cnt  <= HALF_M1;
                        half_idx <= half_idx + 4'd1;
                        if (!half_idx[0]) begin
                            a_smp <= s;
                        end else begin
                            bits <= {bits[3:0], s};
                            if (a_smp == s) man_err <= 1'b1;
                        end
                        if (half_idx == LAST_HALF) begin
                            if (flags == 3'b000) begin
                                rsp_valid <= 1'b1;
                                rsp_data  <= frame[5:2];
                            end else begin
                                rsp_err   <= 1'b1;
                                err_flags <= flags;
                            end
                        end
                    end else begin
                        smp_cnt <= smp_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != ST_IDLE);
    assign rsp_timeout = timeout_hit;
    assign fsm_state   = state;

endmodule
